// File: rtl/func_unit_mc.sv
// func_unit_mc: one warp lane with a private register file, integer ALU and iterative unsigned divider.
// State updates on the falling clock edge; divide/remainder take WIDTH edges after acceptance.
module func_unit_mc #(
  parameter int WIDTH = 32,
  parameter int NUM_REGS = 32,
  localparam int RIDX = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [2:0]                type_instruction,
  input  logic [RIDX-1:0]           regnum_1,
  input  logic [RIDX-1:0]           regnum_2,
  input  logic [RIDX-1:0]           dest_reg,
  input  logic [5:0]                shamt,
  input  logic [NUM_REGS*WIDTH-1:0] init_reg_data,
  input  logic                      is_active,
  output logic [WIDTH-1:0]          final_result,
  output logic                      result_valid,
  output logic                      thread_complete,
  output logic                      busy
);
  typedef enum logic {IDLE, DIV} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] final_q, final_d, quo_q, quo_d, rem_q, rem_d, div_b_q, div_b_d;
  logic [RIDX-1:0] dest_q, dest_d;
  logic rem_op_q, rem_op_d, rv_q, rv_d, tc_q, tc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a, b, alu, rem_n, quo_n, div_res;
  logic [WIDTH:0] rem_sh;
  logic ge;
  assign issue_ready = state_q == IDLE && is_active;
  assign busy = state_q == DIV;
  assign final_result = final_q;
  assign result_valid = rv_q;
  assign thread_complete = tc_q;
  assign a = regs_q[regnum_1];
  assign b = regs_q[regnum_2];
  // Restoring step: shift the next dividend bit into the partial remainder, subtract if divisor fits
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign ge = rem_sh >= {1'b0, div_b_q};
  assign rem_n = ge ? WIDTH'(rem_sh - {1'b0, div_b_q}) : rem_sh[WIDTH-1:0];
  assign quo_n = {quo_q[WIDTH-2:0], ge};
  assign div_res = rem_op_q ? rem_n : quo_n;
  always_comb begin
    case (type_instruction)
      3'b000:  alu = a + b;
      3'b001:  alu = a + ~b + WIDTH'(1);
      3'b010:  alu = a * b;
      3'b011:  alu = '1;
      3'b100:  alu = a;
      3'b101:  alu = int'(shamt) >= WIDTH ? '0 : a << shamt;
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    regs_d = regs_q;
    final_d = final_q;
    rv_d = 1'b0;
    tc_d = tc_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    div_b_d = div_b_q;
    dest_d = dest_q;
    rem_op_d = rem_op_q;
    if (!is_active) tc_d = 1'b1;
    if (state_q == DIV) begin
      quo_d = quo_n;
      rem_d = rem_n;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = IDLE;
        cnt_d = '0;
        regs_d[dest_q] = div_res;
        final_d = div_res;
        rv_d = 1'b1;
      end
    end else if (issue_valid && issue_ready) begin
      tc_d = type_instruction == 3'b111;
      if (type_instruction == 3'b110) begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = init_reg_data[i*WIDTH +: WIDTH];
      end else if ((type_instruction == 3'b011 || type_instruction == 3'b100) && b != '0) begin
        state_d = DIV;
        cnt_d = '0;
        quo_d = a;
        rem_d = '0;
        div_b_d = b;
        dest_d = dest_reg;
        rem_op_d = type_instruction[2];
      end else if (type_instruction != 3'b111) begin
        regs_d[dest_reg] = alu;
        final_d = alu;
        rv_d = 1'b1;
      end
    end
  end
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      final_q <= '0;
      rv_q <= 1'b0;
      tc_q <= 1'b1;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      div_b_q <= '0;
      dest_q <= '0;
      rem_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q <= regs_d;
      final_q <= final_d;
      rv_q <= rv_d;
      tc_q <= tc_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      div_b_q <= div_b_d;
      dest_q <= dest_d;
      rem_op_q <= rem_op_d;
    end
  end
endmodule

// File: tb/tb_func_unit_mc.sv
// tb_func_unit_mc: directed self-checking bench; inputs driven and outputs sampled on rising edges,
// away from the falling edge on which the unit updates.
module tb_func_unit_mc;
  localparam int W = 32;
  localparam int N = 32;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIVU = 3'b011,
                         REMU = 3'b100, SLL = 3'b101, LOAD = 3'b110, EXIT = 3'b111;
  logic clk = 1'b0, rst = 1'b1, issue_valid = 1'b0, is_active = 1'b0;
  logic issue_ready, result_valid, thread_complete, busy;
  logic [2:0] type_instruction = '0;
  logic [4:0] regnum_1 = '0, regnum_2 = '0, dest_reg = '0;
  logic [5:0] shamt = '0;
  logic [N*W-1:0] init_reg_data = '0, img;
  logic [W-1:0] final_result;
  int errs = 0, checks = 0;

  func_unit_mc #(.WIDTH(W), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .type_instruction(type_instruction), .regnum_1(regnum_1), .regnum_2(regnum_2),
    .dest_reg(dest_reg), .shamt(shamt), .init_reg_data(init_reg_data), .is_active(is_active),
    .final_result(final_result), .result_valid(result_valid),
    .thread_complete(thread_complete), .busy(busy));

  always #5 clk = ~clk;

  task automatic set_fields(input logic [2:0] op, input logic [4:0] r1, r2, d, input logic [5:0] sh);
    type_instruction = op; regnum_1 = r1; regnum_2 = r2; dest_reg = d; shamt = sh;
  endtask

  task automatic do_issue(input logic [2:0] op, input logic [4:0] r1, r2, d, input logic [5:0] sh);
    @(posedge clk);
    set_fields(op, r1, r2, d, sh);
    issue_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    checks++; if (final_result !== 32'h0) begin errs++; $display("FAIL rst_final got %h exp 0", final_result); end
    checks++; if (thread_complete !== 1'b1) begin errs++; $display("FAIL rst_tc got %b exp 1", thread_complete); end
    checks++; if (result_valid !== 1'b0) begin errs++; $display("FAIL rst_rv got %b exp 0", result_valid); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL rst_ready_inactive got %b exp 0", issue_ready); end
    @(posedge clk);
    rst = 1'b0;
    is_active = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL rst_ready_active got %b exp 1", issue_ready); end
    do_issue(ADD, 5, 31, 3, 0);
    checks++; if (final_result !== 32'h0) begin errs++; $display("FAIL rst_regs_zero got %h exp 0", final_result); end
    checks++; if (result_valid !== 1'b1) begin errs++; $display("FAIL rst_add_rv got %b exp 1", result_valid); end
    checks++; if (thread_complete !== 1'b0) begin errs++; $display("FAIL rst_add_tc got %b exp 0", thread_complete); end
  endtask

  task automatic test_load_add;
    init_reg_data = img;
    do_issue(LOAD, 0, 0, 0, 0);
    checks++; if (result_valid !== 1'b0) begin errs++; $display("FAIL load_rv got %b exp 0", result_valid); end
    checks++; if (final_result !== 32'h0) begin errs++; $display("FAIL load_final got %h exp 0", final_result); end
    do_issue(ADD, 4, 7, 5, 0);
    checks++; if (final_result !== 32'd33) begin errs++; $display("FAIL add got %h exp 21", final_result); end
    checks++; if (result_valid !== 1'b1) begin errs++; $display("FAIL add_rv got %b exp 1", result_valid); end
    checks++; if (thread_complete !== 1'b0) begin errs++; $display("FAIL add_tc got %b exp 0", thread_complete); end
    @(posedge clk);
    checks++; if (result_valid !== 1'b0) begin errs++; $display("FAIL add_rv_pulse got %b exp 0", result_valid); end
    do_issue(SUB, 4, 7, 6, 0);
    checks++; if (final_result !== 32'hFFFF_FFF7) begin errs++; $display("FAIL sub got %h exp fffffff7", final_result); end
  endtask

  task automatic test_div_back_to_back;
    int n;
    @(posedge clk);
    set_fields(DIVU, 31, 2, 8, 0);
    issue_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL div_busy got %b exp 1", busy); end
    checks++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL div_ready got %b exp 0", issue_ready); end
    set_fields(REMU, 31, 2, 10, 0);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      @(posedge clk);
      checks++; if (result_valid !== (k == W)) begin errs++; $display("FAIL div_rv_edge%0d got %b exp %b", k, result_valid, k == W); end
    end
    checks++; if (final_result !== 32'hF) begin errs++; $display("FAIL divu got %h exp f", final_result); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL divu_busy_done got %b exp 0", busy); end
    @(negedge clk);
    @(posedge clk);
    issue_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL held_accept_busy got %b exp 1", busy); end
    checks++; if (result_valid !== 1'b0) begin errs++; $display("FAIL held_accept_rv got %b exp 0", result_valid); end
    n = 0;
    while (result_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      @(posedge clk);
      n++;
    end
    checks++; if (n !== 32) begin errs++; $display("FAIL remu_latency got %0d exp 32", n); end
    checks++; if (final_result !== 32'd3) begin errs++; $display("FAIL remu got %h exp 3", final_result); end
    do_issue(ADD, 8, 10, 11, 0);
    checks++; if (final_result !== 32'd18) begin errs++; $display("FAIL div_writeback got %h exp 12", final_result); end
  endtask

  task automatic test_div_zero;
    do_issue(DIVU, 4, 0, 9, 0);
    checks++; if (final_result !== 32'hFFFF_FFFF) begin errs++; $display("FAIL divu_zero got %h exp ffffffff", final_result); end
    checks++; if (result_valid !== 1'b1) begin errs++; $display("FAIL divu_zero_rv got %b exp 1", result_valid); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL divu_zero_busy got %b exp 0", busy); end
    do_issue(REMU, 4, 0, 12, 0);
    checks++; if (final_result !== 32'd12) begin errs++; $display("FAIL remu_zero got %h exp c", final_result); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL remu_zero_busy got %b exp 0", busy); end
  endtask

  task automatic test_mul_sll;
    logic [N*W-1:0] img2;
    do_issue(SLL, 4, 0, 14, 4);
    checks++; if (final_result !== 32'd192) begin errs++; $display("FAIL sll4 got %h exp c0", final_result); end
    do_issue(SLL, 4, 0, 15, 40);
    checks++; if (final_result !== 32'h0) begin errs++; $display("FAIL sll40 got %h exp 0", final_result); end
    do_issue(MUL, 3, 7, 17, 0);
    checks++; if (final_result !== 32'd189) begin errs++; $display("FAIL mul got %h exp bd", final_result); end
    img2 = img;
    img2[20*W +: W] = 32'h0001_0000;
    init_reg_data = img2;
    do_issue(LOAD, 0, 0, 0, 0);
    do_issue(MUL, 20, 20, 18, 0);
    checks++; if (final_result !== 32'h0) begin errs++; $display("FAIL mul_wrap got %h exp 0", final_result); end
    checks++; if (result_valid !== 1'b1) begin errs++; $display("FAIL mul_wrap_rv got %b exp 1", result_valid); end
  endtask

  task automatic test_reset_mid_div;
    int pulses;
    do_issue(DIVU, 31, 2, 21, 0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    checks++; if (thread_complete !== 1'b1) begin errs++; $display("FAIL mid_rst_tc got %b exp 1", thread_complete); end
    checks++; if (final_result !== 32'h0) begin errs++; $display("FAIL mid_rst_final got %h exp 0", final_result); end
    @(posedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      if (result_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errs++; $display("FAIL mid_rst_no_rv got %0d exp 0", pulses); end
    checks++; if (final_result !== 32'h0) begin errs++; $display("FAIL mid_rst_final_later got %h exp 0", final_result); end
    do_issue(ADD, 21, 21, 22, 0);
    checks++; if (final_result !== 32'h0) begin errs++; $display("FAIL mid_rst_dest got %h exp 0", final_result); end
  endtask

  task automatic test_inactive_div;
    int n;
    init_reg_data = img;
    do_issue(LOAD, 0, 0, 0, 0);
    do_issue(DIVU, 31, 2, 8, 0);
    is_active = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL inact_ready got %b exp 0", issue_ready); end
    @(negedge clk);
    @(posedge clk);
    checks++; if (thread_complete !== 1'b1) begin errs++; $display("FAIL inact_tc got %b exp 1", thread_complete); end
    n = 0;
    while (result_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      @(posedge clk);
      n++;
    end
    checks++; if (final_result !== 32'hF) begin errs++; $display("FAIL inact_div got %h exp f", final_result); end
    checks++; if (thread_complete !== 1'b1) begin errs++; $display("FAIL inact_div_tc got %b exp 1", thread_complete); end
    repeat (3) @(posedge clk);
    checks++; if (thread_complete !== 1'b1) begin errs++; $display("FAIL inact_tc_hold got %b exp 1", thread_complete); end
    is_active = 1'b1;
    do_issue(ADD, 8, 0, 9, 0);
    checks++; if (final_result !== 32'hF) begin errs++; $display("FAIL inact_writeback got %h exp f", final_result); end
    checks++; if (thread_complete !== 1'b0) begin errs++; $display("FAIL reactivate_tc got %b exp 0", thread_complete); end
  endtask

  task automatic test_exit;
    do_issue(EXIT, 8, 8, 8, 0);
    checks++; if (thread_complete !== 1'b1) begin errs++; $display("FAIL exit_tc got %b exp 1", thread_complete); end
    checks++; if (result_valid !== 1'b0) begin errs++; $display("FAIL exit_rv got %b exp 0", result_valid); end
    checks++; if (final_result !== 32'hF) begin errs++; $display("FAIL exit_final got %h exp f", final_result); end
    do_issue(ADD, 8, 0, 9, 0);
    checks++; if (final_result !== 32'hF) begin errs++; $display("FAIL exit_no_write got %h exp f", final_result); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) img[i*W +: W] = W'(i * 3);
    test_reset();
    test_load_add();
    test_div_back_to_back();
    test_div_zero();
    test_mul_sll();
    test_reset_mid_div();
    test_inactive_div();
    test_exit();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
